// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble), one result bit per clock.
// Optional macro LEADING_ZERO_BLANK_EN: leading zero digits above ones load as 4'hF.

module bin_to_bcd_dig (
    input  logic [3:0] i_d,
    output logic [3:0] o_d
);
    assign o_d = (i_d >= 4'd5) ? i_d + 4'd3 : i_d;
endmodule

module bin_to_bcd_seq #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd
);
    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(WIDTH + 1);

`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [BW-1:0] BCD_RST = {BW{1'b1}} << 4;
`else
    localparam logic [BW-1:0] BCD_RST = '0;
`endif

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

    state_t            r_state, w_state_nxt;
    logic [WIDTH-1:0]  r_sh;
    logic [BW-1:0]     r_scr;
    logic [CW-1:0]     r_cnt;
    logic              r_busy, r_done;
    logic [BW-1:0]     r_bcd;

    logic [BW-1:0]       w_adj;
    logic [BW+WIDTH-1:0] w_shl;
    logic [BW-1:0]       w_bcd_ld;
    logic                w_last;
`ifdef LEADING_ZERO_BLANK_EN
    logic                w_lead;
`endif

    for (genvar g = 0; g < DIGITS; g++) begin : g_dig
        bin_to_bcd_dig u_dig (.i_d(r_scr[4*g +: 4]), .o_d(w_adj[4*g +: 4]));
    end

    assign w_shl  = {w_adj, r_sh} << 1;
    assign w_last = (r_cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start)  w_state_nxt = S_SHIFT;
            S_SHIFT: if (w_last) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_bcd_ld = w_shl[BW+WIDTH-1:WIDTH];
`ifdef LEADING_ZERO_BLANK_EN
        w_lead = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            if (w_lead && (w_bcd_ld[4*i +: 4] == 4'd0)) w_bcd_ld[4*i +: 4] = 4'hF;
            else                                        w_lead = 1'b0;
        end
`endif
    end

    // The final shift's result is written straight into bcd so it is
    // visible, together with done, for the whole DONE cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sh   <= '0;
            r_scr  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_bcd  <= BCD_RST;
        end else begin
            r_busy <= (w_state_nxt != S_IDLE);
            r_done <= (w_state_nxt == S_DONE);
            case (r_state)
                S_IDLE: if (start) begin
                    r_sh  <= bin;
                    r_scr <= '0;
                    r_cnt <= '0;
                end
                S_SHIFT: begin
                    r_sh  <= w_shl[WIDTH-1:0];
                    r_scr <= w_shl[BW+WIDTH-1:WIDTH];
                    r_cnt <= r_cnt + CW'(1);
                    if (w_last) r_bcd <= w_bcd_ld;
                end
                default: ;
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign bcd  = r_bcd;
endmodule

// File: doc/bin_to_bcd_seq.md
BIN_TO_BCD_SEQ -- requirements
Module: bin_to_bcd_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 8: binary input width in bits.
REQ-002 SHALL have parameter DIGITS, default 3: number of BCD output digits; 10^DIGITS SHALL exceed 2^WIDTH-1 (legal pairs only, no check in RTL).
REQ-003 SHALL have port clk  input  1  rising-edge clock; one clock; reset is synchronous and active-low.
REQ-004 SHALL have port rst_n  input  1  synchronous active-low reset, sampled on the clk rising edge.
REQ-005 SHALL have port start  input  1  request to convert bin; sampled each clk edge.
REQ-006 SHALL have port bin  input  WIDTH  unsigned binary value, sampled only on the accepted start cycle.
REQ-007 SHALL have port busy  output  1  conversion in progress; start is ignored while high.
REQ-008 SHALL have port done  output  1  one-cycle pulse: bcd updated this cycle.
REQ-009 SHALL have port bcd  output  4*DIGITS  packed digits: ones in [3:0], tens in [7:4], and so on; each nibble feeds one bcd_to_7led instance directly.

Function
REQ-010 SHALL implement states IDLE, SHIFT and DONE.
REQ-011 IDLE with start=1: SHALL capture bin into a shift register, clear the digit scratch register and the iteration counter, and go to SHIFT.
REQ-012 SHIFT, each cycle: SHALL add 3 to every scratch digit >=5, then shift {scratch, shift reg} left by 1 (double dabble), then increment the counter.
REQ-013 SHIFT SHALL last exactly WIDTH cycles, then go to DONE.
REQ-014 DONE SHALL load the scratch digits into bcd, assert done for that one cycle, and return to IDLE.
REQ-015 Latency: start accepted at edge N SHALL produce done=1 during cycle N+WIDTH+1 (cycle 9 for WIDTH=8).
REQ-016 busy SHALL be 1 in SHIFT and DONE and 0 in IDLE; it SHALL rise the cycle after start is accepted.
REQ-017 start while busy=1, including the DONE cycle, SHALL be ignored with no queuing; the earliest next acceptance is the cycle after done.
REQ-018 Throughput SHALL be one conversion per WIDTH+2 cycles with start held high.
REQ-019 bcd SHALL hold the last result, unchanged during a conversion, and change only in the DONE cycle.
REQ-020 Every output digit SHALL be in 0..9 unless blanked (REQ-026); the maximum input 2^WIDTH-1 SHALL convert exactly.
REQ-021 done and busy SHALL be registered outputs; bcd SHALL be register-driven with no combinational path from start or bin.

Reset
REQ-022 rst_n=0 at a clk edge SHALL force state IDLE, busy=0, done=0, bcd=0 (all digits 0, or blank pattern per REQ-027), and clear the counter and scratch.
REQ-023 Reset during SHIFT or DONE SHALL abort the conversion with no done pulse and no partial bcd update.
REQ-024 start is ignored while rst_n=0; the first start can be accepted at the edge after rst_n returns to 1.

Configuration
REQ-025 Macro LEADING_ZERO_BLANK_EN SHALL select leading-zero blanking.
REQ-026 With LEADING_ZERO_BLANK_EN defined: in the DONE load, every zero digit above ones whose higher digits are all zero SHALL be written as 4'hF (decodes to all segments off); the ones digit SHALL never be blanked.
REQ-027 With LEADING_ZERO_BLANK_EN defined, the reset value of bcd SHALL be all upper digits 4'hF and ones 4'h0.
REQ-028 Without LEADING_ZERO_BLANK_EN: plain BCD is output, with no 4'hF ever produced.

Verification
REQ-029 bin=8'd255, start pulse at cycle 0 -> done=1 only in cycle 9, bcd=12'h255, busy=1 in cycles 1-9.
REQ-030 bin=8'd0 -> bcd=12'h000; with LEADING_ZERO_BLANK_EN bcd=12'hFF0.
REQ-031 bin=8'd7 -> bcd=12'h007 (blanked: 12'hFF7); bin=8'd100 -> 12'h100 (blanking leaves the tens 0 intact).
REQ-032 start=1 with bin=8'd42, then start=1 with bin=8'd99 at cycle 3 -> 99 ignored, bcd=12'h042 at cycle 9, single done pulse.
REQ-033 rst_n=0 at cycle 4 of a conversion of 8'd200 -> no done, bcd=reset value, busy=0 next cycle; start 8'd13 after release -> 12'h013 after 10 cycles.
REQ-034 start held high with bin sweeping 0..255 -> every result matches a reference divide/modulo model, one done per 10 cycles.
